mem_read_ctrl: RTL and testbench

Per-port egress reader for the shared packet buffer. It takes a packet descriptor (head block address) from the port's egress queue and walks the packet's linked list of blocks. Each block is read through the read-arbitration interface of the memory arbiter, and each consumed block is returned to the free list via the arbiter's free channel. Packet bytes go to the TX MAC as a valid/ready byte stream with SOP/EOP.

---
 rtl/mem_read_ctrl_if.sv | 36 +++
 rtl/mem_read_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_read_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_ctrl_if.sv
// rtl/mem_read_ctrl_if.sv - descriptor, arbiter read/free and TX byte stream bundle
interface mem_read_ctrl_if #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_BYTES = 16
);
    localparam int CNT_W      = $clog2(BLOCK_BYTES + 1);
    localparam int BLOCK_BITS = 8 * BLOCK_BYTES + 1 + CNT_W + ADDR_W;

    logic                  desc_valid_i;
    logic [ADDR_W-1:0]     desc_addr_i;
    logic                  desc_ready_o;
    logic                  mem_re_o;
    logic [ADDR_W-1:0]     mem_raddr_o;
    logic                  mem_rvalid_i;
    logic [BLOCK_BITS-1:0] mem_rdata_i;
    logic                  free_req_o;
    logic [ADDR_W-1:0]     free_block_idx_o;
    logic [7:0]            tx_data_o;
    logic                  tx_valid_o;
    logic                  tx_sop_o;
    logic                  tx_eop_o;
    logic                  tx_ready_i;
    logic                  err_o;

    modport master (
        input  desc_valid_i, desc_addr_i, mem_rvalid_i, mem_rdata_i, tx_ready_i,
        output desc_ready_o, mem_re_o, mem_raddr_o, free_req_o, free_block_idx_o,
               tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, err_o
    );

    modport slave (
        output desc_valid_i, desc_addr_i, mem_rvalid_i, mem_rdata_i, tx_ready_i,
        input  desc_ready_o, mem_re_o, mem_raddr_o, free_req_o, free_block_idx_o,
               tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, err_o
    );
endinterface

// File: rtl/mem_read_ctrl.sv
// rtl/mem_read_ctrl.sv - per-port egress reader walking a linked block chain to the TX MAC
module mem_read_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_BYTES = 16,
    parameter int MAX_BLOCKS  = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_read_ctrl_if.master bus
);
    localparam int CNT_W      = $clog2(BLOCK_BYTES + 1);
    localparam int BLOCK_BITS = 8 * BLOCK_BYTES + 1 + CNT_W + ADDR_W;
    localparam int BLK_W      = $clog2(MAX_BLOCKS + 1);

    typedef enum logic [1:0] {IDLE, REQ, STREAM} state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     cur_addr;
    logic [BLOCK_BITS-1:0] blk_buf;
    logic [CNT_W-1:0]      byte_idx;
    logic [BLK_W-1:0]      blk_cnt;
    logic                  sop_flag;
    logic                  free_req;
    logic [ADDR_W-1:0]     free_idx;

    logic [CNT_W-1:0]      cnt_fld;
    logic                  eop_fld;
    logic [ADDR_W-1:0]     next_fld;
    logic [CNT_W-1:0]      eff_cnt;
    logic [CNT_W-1:0]      last_idx;
    logic                  last_byte;
    logic                  at_max;
    logic                  pkt_end;
    logic                  hs;

    logic desc_ready, mem_re, tx_valid, tx_sop, tx_eop, err;

    assign cnt_fld  = blk_buf[8*BLOCK_BYTES +: CNT_W];
    assign eop_fld  = blk_buf[8*BLOCK_BYTES + CNT_W];
    assign next_fld = blk_buf[BLOCK_BITS-1 -: ADDR_W];

    // Out-of-range counts (0 or above BLOCK_BYTES) mean a full block.
    assign eff_cnt   = (cnt_fld == '0 || cnt_fld > CNT_W'(BLOCK_BYTES)) ? CNT_W'(BLOCK_BYTES) : cnt_fld;
    assign last_idx  = eop_fld ? (eff_cnt - CNT_W'(1)) : CNT_W'(BLOCK_BYTES - 1);
    assign last_byte = (byte_idx == last_idx);
    assign at_max    = (blk_cnt == BLK_W'(MAX_BLOCKS));
    assign pkt_end   = eop_fld || at_max;
    assign hs        = (state == STREAM) && bus.tx_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_addr <= '0;
            blk_buf  <= '0;
            byte_idx <= '0;
            blk_cnt  <= '0;
            sop_flag <= 1'b0;
            free_req <= 1'b0;
            free_idx <= '0;
        end else begin
            state    <= state_nxt;
            free_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.desc_valid_i) begin
                        cur_addr <= bus.desc_addr_i;
                        blk_cnt  <= '0;
                        sop_flag <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_rvalid_i) begin
                        blk_buf  <= bus.mem_rdata_i;
                        blk_cnt  <= blk_cnt + BLK_W'(1);
                        byte_idx <= '0;
                        free_req <= 1'b1;
                        free_idx <= cur_addr;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        sop_flag <= 1'b0;
                        if (last_byte) begin
                            byte_idx <= '0;
                            if (!pkt_end) cur_addr <= next_fld;
                        end else begin
                            byte_idx <= byte_idx + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        desc_ready = 1'b0;
        mem_re     = 1'b0;
        tx_valid   = 1'b0;
        tx_sop     = 1'b0;
        tx_eop     = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                desc_ready = 1'b1;
                if (bus.desc_valid_i) state_nxt = REQ;
            end
            REQ: begin
                mem_re = 1'b1;
                if (bus.mem_rvalid_i) state_nxt = STREAM;
            end
            STREAM: begin
                tx_valid = 1'b1;
                tx_sop   = sop_flag && (byte_idx == '0);
                tx_eop   = last_byte && pkt_end;
                if (hs && last_byte) begin
                    err       = !eop_fld && at_max;
                    state_nxt = pkt_end ? IDLE : REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.desc_ready_o     = desc_ready;
    assign bus.mem_re_o         = mem_re;
    assign bus.mem_raddr_o      = (state == REQ) ? cur_addr : '0;
    assign bus.free_req_o       = free_req;
    assign bus.free_block_idx_o = free_req ? free_idx : '0;
    assign bus.tx_data_o        = (state == STREAM) ? blk_buf[{byte_idx, 3'b000} +: 8] : 8'h00;
    assign bus.tx_valid_o       = tx_valid;
    assign bus.tx_sop_o         = tx_sop;
    assign bus.tx_eop_o         = tx_eop;
    assign bus.err_o            = err;
endmodule

// File: tb/tb_mem_read_ctrl.sv
// tb/tb_mem_read_ctrl.sv - directed self-checking bench for mem_read_ctrl
module tb_mem_read_ctrl;
    localparam int ADDR_W = 10;
    localparam int BB     = 16;
    localparam int WB     = 144;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   free_cnt = 0;
    int   req_cnt = 0;
    logic re_d = 1'b0;
    int   f0, r0;

    always #5 clk = ~clk;

    mem_read_ctrl_if #(.ADDR_W(ADDR_W), .BLOCK_BYTES(BB)) bus ();

    mem_read_ctrl #(.ADDR_W(ADDR_W), .BLOCK_BYTES(BB), .MAX_BLOCKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always @(posedge clk) begin
        if (bus.free_req_o) free_cnt++;
        if (bus.mem_re_o && !re_d) req_cnt++;
        re_d <= bus.mem_re_o;
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] make_word(input logic [9:0] nxt, input logic eop,
                                                input logic [4:0] cnt, input logic [7:0] base);
        logic [WB-1:0] w;
        w = '0;
        for (int k = 0; k < BB; k++) w[8*k +: 8] = base + 8'(k);
        w[132:128] = cnt;
        w[133]     = eop;
        w[143:134] = nxt;
        return w;
    endfunction

    task automatic send_desc(input logic [9:0] a);
        bus.desc_valid_i = 1'b1;
        bus.desc_addr_i  = a;
        @(negedge clk);
        bus.desc_valid_i = 1'b0;
        chk(bus.desc_ready_o, 1'b0, "desc_ready_busy");
        chk(bus.mem_re_o, 1'b1, "re_after_accept");
    endtask

    // Latency counts the cycles mem_re_o is seen, including the rvalid cycle.
    task automatic serve(input logic [9:0] a, input int lat, input logic [WB-1:0] w);
        int n = 0;
        while (!bus.mem_re_o && n < 20) begin @(negedge clk); n++; end
        chk(bus.mem_re_o, 1'b1, "re_seen");
        chk(bus.mem_raddr_o, a, "raddr");
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk(bus.mem_raddr_o, a, "raddr_hold");
            chk(bus.free_req_o, 1'b0, "no_free_wait");
        end
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = w;
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        chk(bus.free_req_o, 1'b1, "free_pulse");
        chk(bus.free_block_idx_o, a, "free_idx");
        chk(bus.tx_valid_o, 1'b1, "tx_valid_start");
        chk(bus.mem_re_o, 1'b0, "re_drop");
    endtask

    task automatic recv(input int n, input logic [7:0] base, input bit sop_first,
                        input bit eop_last, input bit trunc, input int stall);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!bus.tx_valid_o && w < 20) begin @(negedge clk); w++; end
            chk(bus.tx_valid_o, 1'b1, "tx_valid");
            chk(bus.tx_data_o, base + 8'(k), "tx_data");
            chk(bus.tx_sop_o, (k == 0) && sop_first, "tx_sop");
            chk(bus.tx_eop_o, (k == n - 1) && eop_last, "tx_eop");
            chk(bus.err_o, (k == n - 1) && trunc, "err");
            if (k == 1) chk(bus.free_req_o, 1'b0, "free_one_cycle");
            if (k == stall) begin
                bus.tx_ready_i = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk(bus.tx_valid_o, 1'b1, "stall_valid");
                    chk(bus.tx_data_o, base + 8'(k), "stall_data");
                    chk(bus.tx_sop_o, 1'b0, "stall_sop");
                    chk(bus.tx_eop_o, 1'b0, "stall_eop");
                    chk(bus.err_o, 1'b0, "stall_err");
                end
                bus.tx_ready_i = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.desc_valid_i = 1'b1;
        bus.desc_addr_i  = 10'h005;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        bus.tx_ready_i   = 1'b1;

        repeat (3) begin
            @(negedge clk);
            chk(bus.desc_ready_o, 1'b1, "rst_desc_ready");
            chk(bus.mem_re_o, 1'b0, "rst_re");
            chk(bus.mem_raddr_o, 0, "rst_raddr");
            chk(bus.tx_valid_o, 1'b0, "rst_tx_valid");
            chk(bus.tx_data_o, 0, "rst_tx_data");
            chk(bus.free_req_o, 1'b0, "rst_free");
            chk(bus.err_o, 1'b0, "rst_err");
            chk({bus.tx_sop_o, bus.tx_eop_o}, 2'b00, "rst_sop_eop");
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.desc_valid_i = 1'b0;
        chk(bus.mem_re_o, 1'b1, "first_re");

        // single block, 5 bytes, latency 3
        serve(10'h005, 3, make_word(10'h000, 1'b1, 5'd5, 8'h10));
        recv(5, 8'h10, 1, 1, 0, -1);
        chk(bus.desc_ready_o, 1'b1, "single_done_idle");
        chk(free_cnt, 1, "single_frees");

        // three-block chain, 35 bytes
        send_desc(10'h010);
        serve(10'h010, 2, make_word(10'h020, 1'b0, 5'd0, 8'h00));
        recv(16, 8'h00, 1, 0, 0, -1);
        serve(10'h020, 2, make_word(10'h030, 1'b0, 5'd0, 8'h10));
        recv(16, 8'h10, 0, 0, 0, -1);
        serve(10'h030, 2, make_word(10'h000, 1'b1, 5'd3, 8'h20));
        recv(3, 8'h20, 0, 1, 0, -1);
        chk(free_cnt, 4, "chain_frees");
        chk(bus.desc_ready_o, 1'b1, "chain_done_idle");

        // backpressure at byte 7
        send_desc(10'h040);
        serve(10'h040, 2, make_word(10'h000, 1'b1, 5'd16, 8'h40));
        recv(16, 8'h40, 1, 1, 0, 7);
        chk(free_cnt, 5, "bp_frees");

        // stray rvalid while idle
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = make_word(10'h3ff, 1'b1, 5'd4, 8'hee);
        @(negedge clk);
        bus.mem_rvalid_i = 1'b0;
        chk(bus.free_req_o, 1'b0, "idle_rvalid_free");
        chk(bus.tx_valid_o, 1'b0, "idle_rvalid_tx");
        chk(bus.desc_ready_o, 1'b1, "idle_rvalid_ready");
        chk(free_cnt, 5, "idle_rvalid_cnt");

        // reset mid-stream at byte 9
        send_desc(10'h050);
        serve(10'h050, 2, make_word(10'h000, 1'b1, 5'd16, 8'h60));
        recv(9, 8'h60, 1, 0, 0, -1);
        chk(bus.tx_data_o, 8'h69, "byte9_before_rst");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk(bus.tx_valid_o, 1'b0, "midrst_tx_valid");
        chk(bus.desc_ready_o, 1'b1, "midrst_ready");
        chk(bus.mem_re_o, 1'b0, "midrst_re");
        chk(bus.free_req_o, 1'b0, "midrst_free");
        chk(free_cnt, 6, "midrst_frees");

        // latency 1, count 20 treated as full block
        send_desc(10'h060);
        serve(10'h060, 1, make_word(10'h000, 1'b1, 5'd20, 8'h80));
        recv(16, 8'h80, 1, 1, 0, -1);

        // latency 7, count 0 treated as full block
        send_desc(10'h070);
        serve(10'h070, 7, make_word(10'h000, 1'b1, 5'd0, 8'ha0));
        recv(16, 8'ha0, 1, 1, 0, -1);
        chk(free_cnt, 8, "lat_frees");

        // truncation at MAX_BLOCKS=4 on a chain without eop
        f0 = free_cnt;
        r0 = req_cnt;
        send_desc(10'h100);
        for (int b = 0; b < 4; b++) begin
            serve(10'h100 + 10'(b), 2, make_word(10'h101 + 10'(b), 1'b0, 5'd0, 8'(b * 16)));
            recv(16, 8'(b * 16), b == 0, b == 3, b == 3, -1);
        end
        repeat (10) @(negedge clk);
        chk(bus.mem_re_o, 1'b0, "trunc_no_5th_re");
        chk(req_cnt - r0, 4, "trunc_reqs");
        chk(free_cnt - f0, 4, "trunc_frees");
        chk(bus.desc_ready_o, 1'b1, "trunc_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
